stream_bit_serializer: RTL



---
 rtl/spi_stream_pkg.sv | 19 +
 rtl/stream_bit_serializer.sv | 88 ++++++++
 2 files changed

// File: rtl/spi_stream_pkg.sv
// Shared definitions for the SPI TX word-stream blocks: FSM state encoding and
// a constant-foldable ceil(log2) used to size bit counters.
package spi_stream_pkg;

    typedef logic [0:0] state_t;

    localparam state_t StIdle  = 1'b0;
    localparam state_t StShift = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_bit_serializer.sv
// Consumes DSIZE-bit words over a vld/ready handshake and shifts them out one bit
// per clk_en strobe, streaming back-to-back words without an idle bit.
module stream_bit_serializer
    import spi_stream_pkg::*;
#(
    parameter int unsigned DSIZE     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             abort,
    input  logic             from_up_vld,
    input  logic [DSIZE-1:0] from_up_data,
    output logic             to_up_ready,
    output logic             sdo,
    output logic             bit_vld,
    output logic             last_bit,
    output logic             word_done
);

    localparam int unsigned     CntW    = clog2(DSIZE);
    localparam logic [CntW-1:0] CntLast = CntW'(DSIZE - 1);

    state_t           state_d, state_q;
    logic [DSIZE-1:0] shreg_d, shreg_q;
    logic [CntW-1:0]  cnt_d, cnt_q;
    logic             word_done_d, word_done_q;
    logic             accept;

    assign bit_vld   = (state_q == StShift);
    assign last_bit  = (state_q == StShift) && (cnt_q == CntLast);
    assign sdo       = MSB_FIRST ? shreg_q[DSIZE-1] : shreg_q[0];
    assign word_done = word_done_q;

    // Gated by rst so ready reads 0 while reset is held, matching the reset outputs.
    assign to_up_ready = clk_en & ~abort & ~rst & ((state_q == StIdle) | last_bit);
    assign accept      = from_up_vld & to_up_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        if (abort) begin
            state_d = StIdle;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (clk_en) begin
            if (state_q == StIdle) begin
                if (accept) begin
                    state_d = StShift;
                    shreg_d = from_up_data;
                    cnt_d   = '0;
                end
            end else if (cnt_q == CntLast) begin
                word_done_d = 1'b1;
                if (accept) begin
                    shreg_d = from_up_data;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end else begin
                // Vacated bit fills with 0 so sdo idles low after the word drains.
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

endmodule
